// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART 8N1 boot loader that writes 16-bit words into program memory.
// Ports: clock, reset, rx in; prog_we/prog_addr/prog_wdata write port; cpu_hold, load_done, load_error, busy status.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CLKS = 1200000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic              busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN, L_LO, L_HI, L_CSUM, L_ERR} ld_state_t;

    rx_state_t       rstate;
    logic            rx_m, rx_s, rx_prev;
    logic [CW-1:0]   bcnt;
    logic [2:0]      bidx;
    logic [7:0]      shreg;
    logic            byte_valid, frame_err;

    ld_state_t       state;
    logic [7:0]      lo, sum;
    logic [8:0]      left;
    logic [TW-1:0]   tcnt;
    logic            tmo;

    // RX front end; shreg holds the last received byte while byte_valid is high
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            rx_prev    <= 1'b1;
            rstate     <= R_IDLE;
            bcnt       <= '0;
            bidx       <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_m       <= rx;
            rx_s       <= rx_m;
            rx_prev    <= rx_s;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            bcnt       <= bcnt + 1'b1;
            unique case (rstate)
                R_IDLE: begin
                    bcnt <= '0;
                    if (rx_prev && !rx_s) rstate <= R_START;
                end
                R_START: if (bcnt == HALF) begin
                    bcnt   <= '0;
                    bidx   <= '0;
                    // a start bit gone high at mid-bit was only a glitch
                    rstate <= rx_s ? R_IDLE : R_DATA;
                end
                R_DATA: if (bcnt == FULL) begin
                    bcnt  <= '0;
                    shreg <= {rx_s, shreg[7:1]};
                    bidx  <= bidx + 3'd1;
                    if (bidx == 3'd7) rstate <= R_STOP;
                end
                R_STOP: if (bcnt == FULL) begin
                    bcnt       <= '0;
                    byte_valid <= rx_s;
                    frame_err  <= !rx_s;
                    rstate     <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign tmo  = (tcnt == TMAX);
    assign busy = (state != L_IDLE);

    always_ff @(posedge clock) begin
        if (reset || state == L_IDLE || byte_valid) tcnt <= '0;
        else if (!tmo) tcnt <= tcnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= L_IDLE;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            lo         <= '0;
            sum        <= '0;
            left       <= '0;
        end else begin
            prog_we   <= 1'b0;
            load_done <= 1'b0;
            if (prog_we) prog_addr <= prog_addr + 1'b1;
            unique case (state)
                L_IDLE: if (byte_valid && shreg == 8'hA5) begin
                    state      <= L_LEN;
                    cpu_hold   <= 1'b1;
                    load_error <= 1'b0;
                    prog_addr  <= '0;
                    sum        <= '0;
                end
                L_LEN: if (byte_valid) begin
                    left  <= (shreg == 8'd0) ? 9'd256 : {1'b0, shreg};
                    sum   <= sum + shreg;
                    state <= L_LO;
                end
                L_LO: if (byte_valid) begin
                    lo    <= shreg;
                    sum   <= sum + shreg;
                    state <= L_HI;
                end
                // stay in HI through the write cycle so prog_we is confined to HI
                L_HI: if (prog_we) begin
                    left  <= left - 9'd1;
                    state <= (left == 9'd1) ? L_CSUM : L_LO;
                end else if (byte_valid) begin
                    prog_we    <= 1'b1;
                    prog_wdata <= {shreg, lo};
                    sum        <= sum + shreg;
                end
                L_CSUM: if (byte_valid) begin
                    if (shreg == sum) load_done <= 1'b1;
                    else load_error <= 1'b1;
                    cpu_hold <= 1'b0;
                    state    <= L_IDLE;
                end
                L_ERR:   state <= L_IDLE;
                default: state <= L_IDLE;
            endcase
            // a byte arriving together with a timeout takes priority
            if (state != L_IDLE && state != L_ERR && !byte_valid
                && (frame_err || tmo)) begin
                state      <= L_ERR;
                load_error <= 1'b1;
                cpu_hold   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed bench for the UART program loader.
// Drives serial frames on rx and checks the program memory write log and status outputs.
module tb_uart_prog_loader;
    localparam int CPB = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        prog_we;
    logic [7:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic        cpu_hold, load_done, load_error, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_done = 0;
    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(8),
        .TIMEOUT_CLKS(500)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx(rx),
        .prog_we(prog_we),
        .prog_addr(prog_addr),
        .prog_wdata(prog_wdata),
        .cpu_hold(cpu_hold),
        .load_done(load_done),
        .load_error(load_error),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (prog_we) begin
            wa.push_back(prog_addr);
            wd.push_back(prog_wdata);
        end
        if (load_done) n_done++;
    end

    typedef struct {
        int          len;
        logic [63:0] bytes;
        int          nwr;
        logic [15:0] d0;
        logic [15:0] d1;
        int          done;
        logic        err;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        rx = stop;
        idle(CPB);
        rx = 1'b1;
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
        n_done = 0;
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_we"}, prog_we, 0);
        chk({pfx, "_addr"}, prog_addr, 0);
        chk({pfx, "_wdata"}, prog_wdata, 0);
        chk({pfx, "_hold"}, cpu_hold, 0);
        chk({pfx, "_done"}, load_done, 0);
        chk({pfx, "_err"}, load_error, 0);
        chk({pfx, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] csum;
        int nw;

        vt[0] = '{7, 64'hA5_02_34_12_CD_AB_C0_00, 2, 16'h1234, 16'hABCD, 1, 1'b0};
        vt[1] = '{7, 64'hA5_02_34_12_CD_AB_1B_00, 2, 16'h1234, 16'hABCD, 0, 1'b1};
        vt[2] = '{8, 64'h00_FF_5A_A5_01_78_56_CF, 1, 16'h5678, 16'h0000, 1, 1'b0};
        vt[3] = '{5, 64'hA5_01_A5_A5_4B_00_00_00, 1, 16'hA5A5, 16'h0000, 1, 1'b0};

        idle(4);
        chk_zero("rst");
        reset = 1'b0;
        idle(4);

        for (int k = 0; k < 4; k++) begin
            clear_log();
            for (int j = 0; j < vt[k].len; j++)
                send_byte(vt[k].bytes[63-8*j -: 8], 1'b1);
            idle(20);
            chk($sformatf("v%0d_nwr", k), wa.size(), vt[k].nwr);
            if (vt[k].nwr > 0) begin
                chk($sformatf("v%0d_a0", k), wa[0], 0);
                chk($sformatf("v%0d_d0", k), wd[0], vt[k].d0);
            end
            if (vt[k].nwr > 1) begin
                chk($sformatf("v%0d_a1", k), wa[1], 1);
                chk($sformatf("v%0d_d1", k), wd[1], vt[k].d1);
            end
            chk($sformatf("v%0d_done", k), n_done, vt[k].done);
            chk($sformatf("v%0d_err", k), load_error, vt[k].err);
            chk($sformatf("v%0d_hold", k), cpu_hold, 0);
            chk($sformatf("v%0d_busy", k), busy, 0);
        end

        // framing error mid-load
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        idle(4);
        chk("fr_hold_on", cpu_hold, 1);
        chk("fr_busy_on", busy, 1);
        send_byte(8'h55, 1'b0);
        idle(20);
        chk("fr_err", load_error, 1);
        chk("fr_hold", cpu_hold, 0);
        chk("fr_busy", busy, 0);
        chk("fr_nwr", wa.size(), 0);

        // short glitch in idle must not disturb the next frame
        clear_log();
        rx = 1'b0;
        idle(2);
        rx = 1'b1;
        idle(3);
        chk("gl_busy", busy, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h78, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'hCF, 1'b1);
        idle(20);
        chk("gl_nwr", wa.size(), 1);
        if (wa.size() > 0) chk("gl_d0", wd[0], 16'h5678);
        chk("gl_done", n_done, 1);
        chk("gl_err", load_error, 0);

        // timeout after a partial frame
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        idle(400);
        chk("to_busy_early", busy, 1);
        chk("to_err_early", load_error, 0);
        idle(150);
        chk("to_err", load_error, 1);
        chk("to_hold", cpu_hold, 0);
        chk("to_busy", busy, 0);
        chk("to_nwr", wa.size(), 0);

        // N=0 means 256 words; address wraps after the last write
        clear_log();
        csum = 8'h00;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send_byte(i[7:0], 1'b1);
            send_byte(i[7:0] ^ 8'h5A, 1'b1);
            csum = csum + i[7:0] + (i[7:0] ^ 8'h5A);
        end
        send_byte(csum, 1'b1);
        idle(20);
        chk("full_nwr", wa.size(), 256);
        nw = (wa.size() < 256) ? wa.size() : 256;
        for (int i = 0; i < nw; i++) begin
            chk($sformatf("full_a%0d", i), wa[i], i[7:0]);
            chk($sformatf("full_d%0d", i), wd[i], {i[7:0] ^ 8'h5A, i[7:0]});
        end
        chk("full_addr_wrap", prog_addr, 0);
        chk("full_done", n_done, 1);
        chk("full_err", load_error, 0);

        // reset in the middle of word 10
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'h10 + i[7:0], 1'b1);
            send_byte(8'h20, 1'b1);
        end
        send_byte(8'h77, 1'b1);
        idle(2);
        chk("mr_nwr_pre", wa.size(), 10);
        chk("mr_hold_pre", cpu_hold, 1);
        reset = 1'b1;
        idle(2);
        chk_zero("mr_in");
        reset = 1'b0;
        send_byte(8'h66, 1'b1);
        idle(20);
        chk("mr_nwr_post", wa.size(), 10);
        chk_zero("mr_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
